// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S defaults, word-select encoding and sample-pair type for the i2so/i2si blocks
package i2s_pkg;
  localparam int I2S_BITS = 16;
  localparam int I2S_CYC_PER_HALF_SCK = 40;
  localparam logic WS_LEFT = 1'b0;
  localparam logic WS_RIGHT = 1'b1;
  typedef struct packed {
    logic [I2S_BITS-1:0] lft;
    logic [I2S_BITS-1:0] rgt;
  } i2s_pair_t;
  function automatic logic ws_for_pos(int pos, int bits);
    return (pos >= bits - 1 && pos <= 2 * bits - 2) ? WS_RIGHT : WS_LEFT;
  endfunction
endpackage

// File: rtl/i2so_serializer_if.sv
// i2so_serializer_if: valid/ready sample-pair handshake from the audio datapath to the I2S transmitter
interface i2so_serializer_if import i2s_pkg::*; #(parameter int BITS = I2S_BITS);
  logic [BITS-1:0] lft;
  logic [BITS-1:0] rgt;
  logic vld;
  logic rdy;
  modport master(output lft, output rgt, output vld, input rdy);
  modport slave(input lft, input rgt, input vld, output rdy);
endinterface

// File: rtl/i2s_sck_gen.sv
// i2s_sck_gen: bit-clock divider producing sck plus single-cycle rise/fall strobes
module i2s_sck_gen import i2s_pkg::*; #(
  parameter int CYC_PER_HALF_SCK = I2S_CYC_PER_HALF_SCK
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);
  localparam int CW = CYC_PER_HALF_SCK > 1 ? $clog2(CYC_PER_HALF_SCK) : 1;
  logic [CW-1:0] sck_cnt;
  logic tc;
  assign tc = sck_cnt == CW'(CYC_PER_HALF_SCK - 1);
  assign rise = en && tc && !sck;
  assign fall = en && tc && sck;
  // half-period counter; sck toggles at terminal count, parked low while disabled
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sck_cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      sck_cnt <= '0;
      sck <= 1'b0;
    end else begin
      sck_cnt <= tc ? '0 : sck_cnt + CW'(1);
      if (tc) sck <= !sck;
    end
endmodule

// File: rtl/i2so_serializer.sv
// i2so_serializer: I2S transmit stage with one-pair holding buffer; optional underrun counter under I2SO_UDR_CNT_EN
module i2so_serializer import i2s_pkg::*; #(
  parameter int BITS = I2S_BITS,
  parameter int CYC_PER_HALF_SCK = I2S_CYC_PER_HALF_SCK
) (
  input  logic clk,
  input  logic rst,
  input  logic rf_i2so_en,
  i2so_serializer_if.slave i2so,
  output logic i2so_sck,
  output logic i2so_ws,
  output logic i2so_sd,
  output logic i2so_udr
`ifdef I2SO_UDR_CNT_EN
  ,
  output logic [7:0] i2so_udr_cnt
`endif
);
  localparam int FW = 2 * BITS;
  localparam int PW = $clog2(FW);
  logic sck_rise, sck_fall;
  logic [PW-1:0] pos;
  logic [FW-1:0] sr, pair_buf, src;
  logic full, load, underrun, capture;
  i2s_sck_gen #(.CYC_PER_HALF_SCK(CYC_PER_HALF_SCK)) u_sck (
    .clk (clk),
    .rst (rst),
    .en  (rf_i2so_en),
    .sck (i2so_sck),
    .rise(sck_rise),
    .fall(sck_fall)
  );
  assign load = sck_fall && pos == '0;
  assign underrun = load && !full;
  assign i2so.rdy = rf_i2so_en && !full;
  assign capture = i2so.vld && i2so.rdy;
  // a frame load takes the buffered pair, or silence when the buffer ran dry
  always_comb src = load ? (full ? pair_buf : '0) : sr;
  // the divider can never raise and lower sck on the same clk
  always_comb assert (!(sck_rise && sck_fall));
  // frame position, shifter, pad outputs and holding buffer; disable clears everything without draining
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pos <= '0;
      sr <= '0;
      pair_buf <= '0;
      full <= 1'b0;
      i2so_ws <= WS_LEFT;
      i2so_sd <= 1'b0;
      i2so_udr <= 1'b0;
    end else if (!rf_i2so_en) begin
      pos <= '0;
      sr <= '0;
      pair_buf <= '0;
      full <= 1'b0;
      i2so_ws <= WS_LEFT;
      i2so_sd <= 1'b0;
      i2so_udr <= 1'b0;
    end else begin
      if (sck_fall) begin
        pos <= pos == PW'(FW - 1) ? '0 : pos + PW'(1);
        sr <= src << 1;
        i2so_sd <= src[FW-1];
        i2so_ws <= ws_for_pos(int'(pos), BITS);
      end
      if (underrun) i2so_udr <= 1'b1;
      if (capture) begin
        pair_buf <= {i2so.lft, i2so.rgt};
        full <= 1'b1;
      end else if (load) full <= 1'b0;
    end
`ifdef I2SO_UDR_CNT_EN
  // saturating count of underrun frame loads
  always_ff @(posedge clk or negedge rst)
    if (!rst) i2so_udr_cnt <= '0;
    else if (!rf_i2so_en) i2so_udr_cnt <= '0;
    else if (underrun && i2so_udr_cnt != 8'hFF) i2so_udr_cnt <= i2so_udr_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_i2so_serializer.sv
// tb_i2so_serializer: frame-level model, receive-side deserializer and directed scenarios for i2so_serializer
module tb_i2so_serializer;
  import i2s_pkg::*;
  localparam int B = 16;
  localparam int C = 40;
  localparam int FW = 2 * B;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic sck, ws, sd, udr;
  int checks = 0, passed = 0;
  i2so_serializer_if #(.BITS(B)) sif();
`ifdef I2SO_UDR_CNT_EN
  logic [7:0] udr_cnt;
`endif
  i2so_serializer #(.BITS(B), .CYC_PER_HALF_SCK(C)) dut (
    .clk(clk),
    .rst(rst),
    .rf_i2so_en(en),
    .i2so(sif),
    .i2so_sck(sck),
    .i2so_ws(ws),
    .i2so_sd(sd),
    .i2so_udr(udr)
`ifdef I2SO_UDR_CNT_EN
    , .i2so_udr_cnt(udr_cnt)
`endif
  );
`ifdef I2SO_UDR_CNT_EN
  logic s_en = 1'b0, s_sck, s_ws, s_sd, s_udr;
  logic [7:0] s_cnt;
  i2so_serializer_if #(.BITS(4)) sif_s();
  i2so_serializer #(.BITS(4), .CYC_PER_HALF_SCK(1)) dut_s (
    .clk(clk),
    .rst(rst),
    .rf_i2so_en(s_en),
    .i2so(sif_s),
    .i2so_sck(s_sck),
    .i2so_ws(s_ws),
    .i2so_sd(s_sd),
    .i2so_udr(s_udr),
    .i2so_udr_cnt(s_cnt)
  );
`endif
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  // frame-level model: time since enable decides sck, every 2C clks is one bit slot
  int k = 0, mfr = -1, mpos = 0, mcnt = 0;
  logic msck = 0, mws = 0, msd = 0, mudr = 0, mfull = 0;
  logic [FW-1:0] mbuf = '0, mword = '0;
  always @(posedge clk) begin : model
    logic rdy_pre;
    if (!rst || !en) begin
      k = 0; mfr = -1; mpos = 0; mcnt = 0;
      msck = 0; mws = 0; msd = 0; mudr = 0; mfull = 0; mbuf = '0; mword = '0;
    end else begin
      rdy_pre = !mfull;
      k++;
      msck = ((k / C) % 2) == 1;
      if (k % (2 * C) == 0) begin
        mpos = (k / (2 * C) - 1) % FW;
        if (mpos == 0) begin
          mfr++;
          if (mfull) begin
            mword = mbuf;
            mfull = 0;
          end else begin
            mword = '0;
            mudr = 1;
            if (mcnt < 255) mcnt++;
          end
        end
        msd = mword[FW-1-mpos];
        mws = mpos >= B - 1 && mpos <= FW - 2;
      end
      if (sif.vld && rdy_pre) begin
        mbuf = {sif.lft, sif.rgt};
        mfull = 1;
      end
    end
  end
  always @(negedge clk) begin
    chk("sck", sck, msck);
    chk("ws", ws, mws);
    chk("sd", sd, msd);
    chk("rdy", sif.rdy, en && !mfull);
    chk("udr", udr, mudr);
`ifdef I2SO_UDR_CNT_EN
    chk("udr_cnt", udr_cnt, 32'(mcnt));
`endif
  end
  // receive-side deserializer: samples sd on sck rise, closes a word when ws changes
  logic psck = 0, lws = 0;
  logic [B-1:0] dsh = '0;
  int nb = 0;
  logic [B-1:0] words[$];
  always @(negedge clk)
    if (!en) begin
      nb = 0; lws = 0; psck = 0;
    end else begin
      if (sck && !psck) begin
        dsh = {dsh[B-2:0], sd};
        nb++;
        if (ws != lws && nb >= B) begin
          words.push_back(dsh);
          nb = 0;
        end
        lws = ws;
      end
      psck = sck;
    end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic send(input logic [B-1:0] l, input logic [B-1:0] r);
    bit got = 0;
    sif.lft = l; sif.rgt = r; sif.vld = 1'b1;
    for (int n = 0; n < 6000 && !got; n++) begin
      #1;
      got = sif.rdy;
      tick();
    end
    chk("accept", 32'(got), 1);
    if (got) chk("rdy_drop", sif.rdy, 0);
    sif.vld = 1'b0;
  endtask
  task automatic wait_pos(input int f, input int p);
    int n = 0;
    while (!(mfr == f && mpos == p) && n < 8000) begin
      tick();
      n++;
    end
    chk($sformatf("reach_f%0d_p%0d", f, p), 32'(mfr == f && mpos == p), 1);
  endtask
  i2s_pair_t strm[11] = '{32'h1478A3B9, 32'hCDD7BABA, 32'h00018000, 32'hFFFF0000, 32'h5A5AA5A5,
                          32'h0F0FF0F0, 32'h80017FFE, 32'h13572468, 32'hDEADBEEF, 32'hC3C33C3C, 32'h7398FFDD};
  logic [B-1:0] exp_w[$];
  initial begin
    int n1, n2;
    sif.vld = 1'b0; sif.lft = '0; sif.rgt = '0;
`ifdef I2SO_UDR_CNT_EN
    sif_s.vld = 1'b0; sif_s.lft = '0; sif_s.rgt = '0;
`endif
    repeat (10) tick();
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 0);
    chk("rst_sd", sd, 0);
    chk("rst_rdy", sif.rdy, 0);
    chk("rst_udr", udr, 0);
    rst = 1'b1;
    tick();
    chk("dis_rdy", sif.rdy, 0);
    en = 1'b1;
    send(16'hAAAA, 16'hFFFF);
    wait_pos(0, 0);
    chk("f0p0_sd", sd, 1);
    chk("f0p0_ws", ws, 0);
    wait_pos(0, 1);
    chk("f0p1_sd", sd, 0);
    wait_pos(0, 14);
    chk("f0p14_ws", ws, 0);
    chk("f0p14_sd", sd, 1);
    wait_pos(0, 15);
    chk("f0p15_ws", ws, 1);
    chk("f0p15_sd", sd, 0);
    wait_pos(0, 16);
    chk("f0p16_sd", sd, 1);
    for (int i = 0; i < 11; i++) send(strm[i].lft, strm[i].rgt);
    chk("stream_udr", udr, 0);
    wait_pos(12, 0);
    chk("underrun_udr", udr, 1);
    chk("underrun_sd", sd, 0);
    send(16'h1111, 16'h5982);
    wait_pos(14, 0);
    chk("udr_sticky", udr, 1);
    exp_w.push_back(16'hAAAA);
    exp_w.push_back(16'hFFFF);
    for (int i = 0; i < 11; i++) begin
      exp_w.push_back(strm[i].lft);
      exp_w.push_back(strm[i].rgt);
    end
    exp_w.push_back(16'h0000);
    exp_w.push_back(16'h0000);
    exp_w.push_back(16'h1111);
    exp_w.push_back(16'h5982);
    chk("rx_count", 32'(words.size() >= exp_w.size()), 1);
    for (int i = 0; i < exp_w.size() && i < words.size(); i++) chk($sformatf("rx_word%0d", i), words[i], exp_w[i]);
    send(16'hFFFF, 16'hFFFF);
    wait_pos(15, 0);
    send(16'h1234, 16'h5678);
    wait_pos(15, 7);
    n1 = 0;
    while (!msck && n1 < 200) begin
      tick();
      n1++;
    end
    chk("pre_dis_sck", sck, 1);
    chk("pre_dis_sd", sd, 1);
    chk("pre_dis_udr", udr, 1);
    en = 1'b0;
    tick();
    chk("dis_sck", sck, 0);
    chk("dis_ws", ws, 0);
    chk("dis_sd", sd, 0);
    chk("dis_rdy", sif.rdy, 0);
    chk("dis_udr", udr, 0);
    repeat (5) tick();
    en = 1'b1;
    #1;
    chk("reen_rdy", sif.rdy, 1);
    n1 = 0;
    while (!sck && n1 < 200) begin
      tick();
      n1++;
    end
    chk("first_rise", 32'(n1), 40);
    n1 = 0;
    while (sck && n1 < 200) begin
      tick();
      n1++;
    end
    n2 = 0;
    while (!sck && n2 < 200) begin
      tick();
      n2++;
    end
    chk("sck_period", 32'(n1 + n2), 80);
    chk("reen_udr", udr, 1);
    chk("reen_frame", 32'(mfr), 0);
`ifdef I2SO_UDR_CNT_EN
    s_en = 1'b1;
    repeat (18) tick();
    chk("s_cnt2", s_cnt, 2);
    chk("s_udr", s_udr, 1);
    repeat (16 * 300) tick();
    chk("s_cnt_sat", s_cnt, 8'hFF);
    s_en = 1'b0;
    tick();
    chk("s_cnt_clr", s_cnt, 0);
    chk("s_udr_clr", s_udr, 0);
    chk("s_sck_clr", {s_sck, s_ws, s_sd}, 0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/i2so_serializer.md
Name: i2so_serializer

Overview:
- I2S transmit stage; mirror of the i2si deserializer.
- Accepts parallel 16-bit left/right sample pairs from the audio datapath through a valid/ready handshake.
- Generates the I2S bit clock, word select and serial data on the pad side.
- Holds one pair in a holding buffer so upstream has a full frame time to supply the next pair.

Parameters:
- BITS, 16, bits per channel word (frame = 2*BITS sck periods)
- CYC_PER_HALF_SCK, 40, clk cycles per sck half-period (100 MHz / 1.25 MHz / 2)

Ports:
- clk  input  1  master clock, 100 MHz
- rst  input  1  reset, asynchronous, active-low
- rf_i2so_en  input  1  block enable from register file
- i2so_lft  input  BITS  left sample, MSB first on the wire
- i2so_rgt  input  BITS  right sample
- i2so_vld  input  1  sample pair valid
- i2so_rdy  output  1  holding buffer empty; pair accepted when vld&rdy at posedge clk
- i2so_sck  output  1  serial bit clock
- i2so_ws  output  1  word select, 0 = left slot, 1 = right slot
- i2so_sd  output  1  serial data, changes on sck falling edge
- i2so_udr  output  1  sticky underrun flag, cleared by disable

Behaviour:
- Reset (rst=0): all outputs 0; counters, shift register and holding buffer cleared; buffer marked empty.
- Disabled (rf_i2so_en=0):
  - Same state as reset on the next clk. Takes effect mid-frame with no drain.
  - rdy=0 and udr cleared.
- Divider:
  - sck_cnt counts 0..CYC_PER_HALF_SCK-1.
  - At terminal count, sck_cnt returns to 0 and sck toggles.
  - After enable, sck rises after CYC_PER_HALF_SCK clks and falls after 2*CYC_PER_HALF_SCK clks.
- Shift event: the clk on which sck is toggled 1->0. All sd/ws updates happen only on shift events, so they are registered and stable across the sck rising edge.
- Frame position: bit_pos counts 0..2*BITS-1 and wraps. The first shift event after enable drives bit_pos=0.
- Frame load (shift event with bit_pos=0):
  - If the buffer is full: shift register <= {lft,rgt} and the buffer is marked empty.
  - If the buffer is empty: shift register <= 0 and udr <= 1.
- sd: at each shift event, sd <= shift register MSB and the shift register shifts left by 1.
- ws (standard I2S one-bit lead): at a shift event driving bit_pos=p, ws <= 1 when p in [BITS-1, 2*BITS-2], else 0. ws therefore changes one sck before each word's MSB.
- Handshake:
  - rdy = enabled & buffer empty.
  - vld&rdy captures lft/rgt into the buffer and marks it full on the next clk.
  - vld while rdy=0 is ignored; upstream holds.
  - Simultaneous frame load and capture on the same clk:
    - The load takes the old buffer contents, or underruns if the buffer is empty.
    - The capture fills the buffer for the next frame.
    - No loss occurs.
- Latency: a pair accepted while the buffer is empty and the block idle appears with its left MSB on sd at the next bit_pos=0 shift event.
- Wrap: bit_pos 2*BITS-1 -> 0 triggers the next frame load; no gap between frames.

Optional Feature:
- Macro I2SO_UDR_CNT_EN.
- When defined:
  - Adds output i2so_udr_cnt [7:0].
  - Increments on each underrun frame load and saturates at 8'hFF.
  - Cleared by reset or disable.
- When undefined: the port and counter are absent; the sticky i2so_udr flag is unchanged either way.

Decomposition:
- Shared package i2s_pkg:
  - BITS and CYC_PER_HALF_SCK defaults.
  - WS_LEFT/WS_RIGHT constants.
  - Sample-pair typedef, also used by the i2si deserializer.
- One natural sub-module: i2s_sck_gen. It holds the divider and emits sck plus single-cycle rise/fall strobes, reusable by the receive-side bench.

Test Plan:
- Reset/idle: rst low for 10 clks with en=0 -> sck=ws=sd=rdy=udr=0; rdy=0 while en=0.
- Single pair: en=1, present lft=16'hAAAA, rgt=16'hFFFF with vld -> rdy drops one clk later. sd carries 1010...10 during ws=0 slot, then sixteen 1s during ws=1 slot. ws rises one sck before the right MSB. sck period = 80 clks.
- Streaming: 11 pairs supplied back-to-back whenever rdy (e.g. 16'h1478/16'hA3B9, 16'hCDD7/16'hBABA, ...) -> a checker deserializer captures all 22 words exactly in order, udr stays 0, no idle sck periods.
- Underrun: stop supplying after pair 16'h7398/16'hFFDD -> next frame sd all 0, udr=1 and sticky. Resume with 16'h1111/16'h5982 -> that pair is transmitted in the following frame, and udr stays 1 until en toggles.
- Mid-frame disable: drop en at bit_pos=7 of the left slot -> next clk sck=ws=sd=0 and rdy=0. Re-enable -> first sck rise after 40 clks, and the frame restarts at bit_pos=0 with underrun (buffer cleared).
- I2SO_UDR_CNT_EN build: force 300 consecutive underrun frames -> i2so_udr_cnt saturates at 8'hFF. Disable -> count returns to 0.
